// File: rtl/data_mem_responder.sv
// Word-organised data RAM on the core data port: lane-steered stores, zero-extended loads,
// and sticky logging of misaligned or out-of-range stores.
module data_mem_responder #(
   parameter int          ADDR_WIDTH = 8,
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
   parameter int          CNT_WIDTH  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 DWe,
   input  logic [31:0]          DAddr,
   input  logic [31:0]          DWrData,
   input  logic [1:0]           BHW,
   output logic [31:0]          DRdData,
   output logic                 hit,
   input  logic                 err_clr,
   output logic                 err_flag,
   output logic [31:0]          err_addr,
   output logic [CNT_WIDTH-1:0] err_cnt
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [31:0]           mem [DEPTH];
   logic [ADDR_WIDTH-1:0] widx;
   logic [1:0]            off;
   logic                  mis;
   logic                  fault;
   logic                  wr_en;
   logic [3:0]            lane_en;
   logic [31:0]           lane_dat;
   logic [31:0]           rd_word;
   logic [31:0]           rd_shift;

   assign widx  = DAddr[ADDR_WIDTH+1:2];
   assign off   = DAddr[1:0];
   assign hit   = (DAddr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
   assign mis   = ((BHW == 2'b01) & off[0]) | (BHW[1] & (off != 2'b00));
   assign fault = DWe & (mis | ~hit);
   assign wr_en = DWe & hit & ~mis;

   // Store data is replicated across lanes so the lane enables alone pick the target bytes.
   always_comb begin
      lane_en  = 4'b0000;
      lane_dat = DWrData;
      case (BHW)
         2'b00: begin
            lane_en  = 4'b0001 << off;
            lane_dat = {4{DWrData[7:0]}};
         end
         2'b01: begin
            lane_en  = 4'b0011 << off;
            lane_dat = {2{DWrData[15:0]}};
         end
         default: begin
            lane_en  = 4'b1111;
            lane_dat = DWrData;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (wr_en && lane_en[i]) begin
            mem[widx][8*i +: 8] <= lane_dat[8*i +: 8];
         end
      end
   end

   assign rd_word  = mem[widx];
   assign rd_shift = rd_word >> {off, 3'b000};

   always_comb begin
      DRdData = 32'h0;
      if (hit) begin
         case (BHW)
            2'b00:   DRdData = {24'h0, rd_shift[7:0]};
            2'b01:   DRdData = {16'h0, rd_shift[15:0]};
            default: DRdData = rd_shift;
         endcase
      end
   end

   // A fault in the same cycle as err_clr restarts the log with this fault as the first one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_flag <= 1'b0;
         err_addr <= 32'h0;
         err_cnt  <= '0;
      end else if (fault) begin
         err_flag <= 1'b1;
         if (!err_flag || err_clr) begin
            err_addr <= DAddr;
         end
         if (err_clr) begin
            err_cnt <= CNT_WIDTH'(1);
         end else if (err_cnt != {CNT_WIDTH{1'b1}}) begin
            err_cnt <= err_cnt + CNT_WIDTH'(1);
         end
      end else if (err_clr) begin
         err_flag <= 1'b0;
         err_addr <= 32'h0;
         err_cnt  <= '0;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: stores, loads, fault logging, clear and saturation.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        DWe;
   logic [31:0] DAddr;
   logic [31:0] DWrData;
   logic [1:0]  BHW;
   logic [31:0] DRdData;
   logic        hit;
   logic        err_clr;
   logic        err_flag;
   logic [31:0] err_addr;
   logic [7:0]  err_cnt;

   int pass_cnt = 0;
   int total    = 0;

   data_mem_responder #(
      .ADDR_WIDTH(8),
      .BASE_ADDR (32'h1000_0000),
      .CNT_WIDTH (8)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .DWe     (DWe),
      .DAddr   (DAddr),
      .DWrData (DWrData),
      .BHW     (BHW),
      .DRdData (DRdData),
      .hit     (hit),
      .err_clr (err_clr),
      .err_flag(err_flag),
      .err_addr(err_addr),
      .err_cnt (err_cnt)
   );

   always #5 clk = ~clk;

   // One store cycle: inputs set at negedge, the store edge passes, strobe dropped at next negedge.
   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      @(negedge clk);
      DWe = 1'b1; DAddr = a; DWrData = d; BHW = s;
      @(negedge clk);
      DWe = 1'b0;
   endtask

   task automatic load(input logic [31:0] a, input logic [1:0] s);
      DAddr = a; BHW = s;
      #1;
   endtask

   task automatic test_reset;
      #1;
      if (err_flag !== 1'b0) $display("FAIL reset_flag: got %b want 0", err_flag); else pass_cnt++;
      total++;
      if (err_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", err_addr); else pass_cnt++;
      total++;
      if (err_cnt !== 8'h0) $display("FAIL reset_cnt: got %h want 0", err_cnt); else pass_cnt++;
      total++;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_word_store;
      store(32'h1000_0010, 32'hDEAD_BEEF, 2'b10);
      load(32'h1000_0010, 2'b10);
      if (DRdData !== 32'hDEAD_BEEF) $display("FAIL word_rd: got %h want deadbeef", DRdData); else pass_cnt++;
      total++;
      if (hit !== 1'b1) $display("FAIL word_hit: got %b want 1", hit); else pass_cnt++;
      total++;
      if (err_flag !== 1'b0) $display("FAIL word_noerr: got %b want 0", err_flag); else pass_cnt++;
      total++;
   endtask

   task automatic test_byte_store;
      store(32'h1000_0012, 32'h0000_00A5, 2'b00);
      load(32'h1000_0010, 2'b10);
      if (DRdData !== 32'hDEA5_BEEF) $display("FAIL byte_word_rd: got %h want dea5beef", DRdData); else pass_cnt++;
      total++;
      load(32'h1000_0012, 2'b00);
      if (DRdData !== 32'h0000_00A5) $display("FAIL byte_rd: got %h want 000000a5", DRdData); else pass_cnt++;
      total++;
      load(32'h1000_0012, 2'b01);
      if (DRdData !== 32'h0000_DEA5) $display("FAIL half_rd: got %h want 0000dea5", DRdData); else pass_cnt++;
      total++;
      load(32'h1000_0013, 2'b01);
      if (DRdData !== 32'h0000_00DE) $display("FAIL half_rd_off3: got %h want 000000de", DRdData); else pass_cnt++;
      total++;
   endtask

   task automatic test_misaligned;
      store(32'h1000_0011, 32'h0000_1234, 2'b01);
      load(32'h1000_0010, 2'b10);
      if (DRdData !== 32'hDEA5_BEEF) $display("FAIL mis_nowrite: got %h want dea5beef", DRdData); else pass_cnt++;
      total++;
      if (err_flag !== 1'b1) $display("FAIL mis_flag: got %b want 1", err_flag); else pass_cnt++;
      total++;
      if (err_addr !== 32'h1000_0011) $display("FAIL mis_addr: got %h want 10000011", err_addr); else pass_cnt++;
      total++;
      if (err_cnt !== 8'd1) $display("FAIL mis_cnt: got %0d want 1", err_cnt); else pass_cnt++;
      total++;
      store(32'h1000_0022, 32'h5555_5555, 2'b10);
      if (err_addr !== 32'h1000_0011) $display("FAIL mis2_addr: got %h want 10000011", err_addr); else pass_cnt++;
      total++;
      if (err_cnt !== 8'd2) $display("FAIL mis2_cnt: got %0d want 2", err_cnt); else pass_cnt++;
      total++;
   endtask

   task automatic test_out_of_range;
      store(32'h1000_0000, 32'hCAFE_F00D, 2'b10);
      @(negedge clk);
      DWe = 1'b1; DAddr = 32'h2000_0000; DWrData = 32'hFFFF_FFFF; BHW = 2'b10;
      #1;
      if (hit !== 1'b0) $display("FAIL oor_hit: got %b want 0", hit); else pass_cnt++;
      total++;
      @(negedge clk);
      DWe = 1'b0;
      if (err_cnt !== 8'd3) $display("FAIL oor_cnt: got %0d want 3", err_cnt); else pass_cnt++;
      total++;
      load(32'h2000_0000, 2'b10);
      if (DRdData !== 32'h0) $display("FAIL oor_rd: got %h want 0", DRdData); else pass_cnt++;
      total++;
      load(32'h1000_0000, 2'b10);
      if (DRdData !== 32'hCAFE_F00D) $display("FAIL oor_alias: got %h want cafef00d", DRdData); else pass_cnt++;
      total++;
      load(32'h1000_03FC, 2'b10);
      if (hit !== 1'b1) $display("FAIL hit_top: got %b want 1", hit); else pass_cnt++;
      total++;
      load(32'h1000_0400, 2'b10);
      if (hit !== 1'b0) $display("FAIL hit_past_end: got %b want 0", hit); else pass_cnt++;
      total++;
      load(32'h0FFF_FFFC, 2'b10);
      if (hit !== 1'b0) $display("FAIL hit_below_base: got %b want 0", hit); else pass_cnt++;
      total++;
   endtask

   task automatic test_clear;
      @(negedge clk);
      err_clr = 1'b1; DWe = 1'b1; DAddr = 32'h1000_0001; DWrData = 32'h0000_7777; BHW = 2'b01;
      @(negedge clk);
      DWe = 1'b0;
      if (err_flag !== 1'b1) $display("FAIL clrfault_flag: got %b want 1", err_flag); else pass_cnt++;
      total++;
      if (err_addr !== 32'h1000_0001) $display("FAIL clrfault_addr: got %h want 10000001", err_addr); else pass_cnt++;
      total++;
      if (err_cnt !== 8'd1) $display("FAIL clrfault_cnt: got %0d want 1", err_cnt); else pass_cnt++;
      total++;
      @(negedge clk);
      err_clr = 1'b0;
      if (err_flag !== 1'b0) $display("FAIL clr_flag: got %b want 0", err_flag); else pass_cnt++;
      total++;
      if (err_addr !== 32'h0) $display("FAIL clr_addr: got %h want 0", err_addr); else pass_cnt++;
      total++;
      if (err_cnt !== 8'd0) $display("FAIL clr_cnt: got %0d want 0", err_cnt); else pass_cnt++;
      total++;
   endtask

   task automatic test_read_during_write;
      @(negedge clk);
      DWe = 1'b1; DAddr = 32'h1000_0010; DWrData = 32'h1122_3344; BHW = 2'b10;
      #1;
      if (DRdData !== 32'hDEA5_BEEF) $display("FAIL rdw_old: got %h want dea5beef", DRdData); else pass_cnt++;
      total++;
      @(negedge clk);
      DWe = 1'b0;
      if (DRdData !== 32'h1122_3344) $display("FAIL rdw_new: got %h want 11223344", DRdData); else pass_cnt++;
      total++;
      store(32'h1000_0012, 32'hFFFF_ABCD, 2'b01);
      load(32'h1000_0010, 2'b10);
      if (DRdData !== 32'hABCD_3344) $display("FAIL half_upper: got %h want abcd3344", DRdData); else pass_cnt++;
      total++;
   endtask

   task automatic test_saturation;
      @(negedge clk);
      DWe = 1'b1; DAddr = 32'h2000_0000; DWrData = 32'h0; BHW = 2'b10;
      repeat (300) @(negedge clk);
      if (err_cnt !== 8'hFF) $display("FAIL sat_cnt: got %h want ff", err_cnt); else pass_cnt++;
      total++;
      if (err_addr !== 32'h2000_0000) $display("FAIL sat_addr: got %h want 20000000", err_addr); else pass_cnt++;
      total++;
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      if (err_flag !== 1'b0) $display("FAIL async_rst_flag: got %b want 0", err_flag); else pass_cnt++;
      total++;
      if (err_cnt !== 8'h0) $display("FAIL async_rst_cnt: got %h want 0", err_cnt); else pass_cnt++;
      total++;
      @(negedge clk);
      DWe = 1'b0;
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0; DWe = 1'b0; DAddr = 32'h0; DWrData = 32'h0; BHW = 2'b10; err_clr = 1'b0;
      test_reset;
      test_word_store;
      test_byte_store;
      test_misaligned;
      test_out_of_range;
      test_clear;
      test_read_during_write;
      test_saturation;
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
